iob2axi_arb: RTL and testbench

IOB2AXI_ARB -- requirements
Module: iob2axi_arb

---
 rtl/iob2axi_arb.sv | 137 +++++++++++++
 tb/tb_iob2axi_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob2axi_arb.sv
// Two-port round-robin arbiter in front of a native-to-AXI bridge.
// A grant holds the bridge for one burst of sN_len+1 beats, then drains.
module iob2axi_arb #(
    parameter int ADDR_W = 0,
    parameter int DATA_W = 0,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s0_valid,
    input  logic [ADDR_W-1:0]   s0_addr,
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    input  logic [LEN_W-1:0]    s0_len,
    output logic [DATA_W-1:0]   s0_rdata,
    output logic                s0_ready,
    output logic                s0_error,
    input  logic                s1_valid,
    input  logic [ADDR_W-1:0]   s1_addr,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    input  logic [LEN_W-1:0]    s1_len,
    output logic [DATA_W-1:0]   s1_rdata,
    output logic                s1_ready,
    output logic                s1_error,
    output logic                m_valid,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready,
    output logic [LEN_W-1:0]    m_length,
    input  logic                m_idle,
    input  logic                m_error,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    state_t           state, state_nx;
    logic             gnt, gnt_nx;
    logic             last, last_nx;
    logic [LEN_W:0]   cnt, cnt_nx;
    logic [LEN_W-1:0] len_q, len_nx;
    logic [1:0]       err, err_nx;
    logic             pick;
    logic             in_burst;
    logic             g_valid;
    logic             beat;

    // On a tie the port that did not win last time gets the bus.
    assign pick     = (s0_valid & s1_valid) ? ~last : s1_valid;
    assign in_burst = (state == BURST);
    assign g_valid  = gnt ? s1_valid : s0_valid;
    assign beat     = m_valid & m_ready;

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        last_nx  = last;
        cnt_nx   = cnt;
        len_nx   = len_q;
        err_nx   = err;
        unique case (state)
            IDLE: begin
                if (m_idle && (s0_valid || s1_valid)) begin
                    state_nx     = BURST;
                    gnt_nx       = pick;
                    len_nx       = pick ? s1_len : s0_len;
                    cnt_nx       = '0;
                    err_nx[pick] = 1'b0;
                end
            end
            BURST: begin
                if (beat) begin
                    cnt_nx = cnt + CNT_ONE;
                    if (cnt == {1'b0, len_q}) begin
                        state_nx = DRAIN;
                    end
                end
                if (m_error) begin
                    err_nx[gnt] = 1'b1;
                end
            end
            DRAIN: begin
                if (m_error) begin
                    err_nx[gnt] = 1'b1;
                end
                if (m_idle) begin
                    state_nx = IDLE;
                    last_nx  = gnt;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            cnt   <= '0;
            len_q <= '0;
            err   <= '0;
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
            len_q <= len_nx;
            err   <= err_nx;
        end
    end

    // Native side is a pure mux of the granted port while bursting.
    assign m_valid  = in_burst & g_valid;
    assign m_addr   = in_burst ? (gnt ? s1_addr : s0_addr) : '0;
    assign m_wdata  = in_burst ? (gnt ? s1_wdata : s0_wdata) : '0;
    assign m_wstrb  = in_burst ? (gnt ? s1_wstrb : s0_wstrb) : '0;
    assign m_length = len_q;

    assign s0_ready = in_burst & ~gnt & m_ready;
    assign s1_ready = in_burst & gnt & m_ready;
    assign s0_rdata = (in_burst & ~gnt) ? m_rdata : '0;
    assign s1_rdata = (in_burst & gnt) ? m_rdata : '0;
    assign s0_error = err[0];
    assign s1_error = err[1];
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_iob2axi_arb.sv
// Directed vector bench for iob2axi_arb: per-cycle table plus
// a hand sequence for length latching and back-to-back grant.
module tb_iob2axi_arb;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int SW     = DATA_W / 8;

    localparam logic [ADDR_W-1:0] A0 = 16'h1000;
    localparam logic [ADDR_W-1:0] A1 = 16'h2000;
    localparam logic [DATA_W-1:0] D0 = 32'hAAAA_0000;
    localparam logic [DATA_W-1:0] D1 = 32'h5555_1111;
    localparam logic [SW-1:0]     W0 = 4'hF;
    localparam logic [SW-1:0]     W1 = 4'h0;

    logic              clk = 1'b0;
    logic              rst;
    logic              s0_valid, s1_valid;
    logic [ADDR_W-1:0] s0_addr, s1_addr;
    logic [DATA_W-1:0] s0_wdata, s1_wdata;
    logic [SW-1:0]     s0_wstrb, s1_wstrb;
    logic [LEN_W-1:0]  s0_len, s1_len;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;
    logic              s0_ready, s1_ready;
    logic              s0_error, s1_error;
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;
    logic [LEN_W-1:0]  m_length;
    logic              m_idle;
    logic              m_error;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob2axi_arb #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s0_valid(s0_valid),
        .s0_addr (s0_addr),
        .s0_wdata(s0_wdata),
        .s0_wstrb(s0_wstrb),
        .s0_len  (s0_len),
        .s0_rdata(s0_rdata),
        .s0_ready(s0_ready),
        .s0_error(s0_error),
        .s1_valid(s1_valid),
        .s1_addr (s1_addr),
        .s1_wdata(s1_wdata),
        .s1_wstrb(s1_wstrb),
        .s1_len  (s1_len),
        .s1_rdata(s1_rdata),
        .s1_ready(s1_ready),
        .s1_error(s1_error),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_length(m_length),
        .m_idle  (m_idle),
        .m_error (m_error),
        .busy    (busy)
    );

    typedef struct packed {
        logic       rst;
        logic       v0;
        logic       v1;
        logic [7:0] l0;
        logic [7:0] l1;
        logic       mrdy;
        logic       midle;
        logic       merr;
        logic       busy;
        logic       mv;
        logic       rdy0;
        logic       rdy1;
        logic [7:0] mlen;
        logic       e0;
        logic       e1;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input int r, input int v0, input int v1, input int l0,
        input int l1, input int mr, input int mi, input int me,
        input int b, input int mv, input int r0, input int r1,
        input int ml, input int e0, input int e1, input int sel);
        vec_t x;
        x.rst   = r[0];
        x.v0    = v0[0];
        x.v1    = v1[0];
        x.l0    = l0[7:0];
        x.l1    = l1[7:0];
        x.mrdy  = mr[0];
        x.midle = mi[0];
        x.merr  = me[0];
        x.busy  = b[0];
        x.mv    = mv[0];
        x.rdy0  = r0[0];
        x.rdy1  = r1[0];
        x.mlen  = ml[7:0];
        x.e0    = e0[0];
        x.e1    = e1[0];
        x.sel   = sel[1:0];
        return x;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h",
                     nm, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_addr = A0; s1_addr = A1;
        s0_wdata = D0; s1_wdata = D1;
        s0_wstrb = W0; s1_wstrb = W1;
        s0_len = '0; s1_len = '0;
        m_rdata = '0; m_ready = 1'b0;
        m_idle = 1'b1; m_error = 1'b0;

        // rst v0 v1 l0 l1 mrdy midle merr | busy mv r0 r1 mlen e0 e1 sel
        // tie arbitration from reset: s0, s1, s0
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 1,1,1,0,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 1,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 1,1,0,1,0,0,0,2));
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 1,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 1,1,1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1,0, 1,0,0,0,0,0,0,0));
        // s0 write len=3, bridge busy during burst
        tbl.push_back(mk(0,1,0,3,0,1,1,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,3,0,1,0,0, 1,1,1,0,3,0,0,1));
        tbl.push_back(mk(0,1,0,3,0,1,0,0, 1,1,1,0,3,0,0,1));
        tbl.push_back(mk(0,1,0,3,0,1,0,0, 1,1,1,0,3,0,0,1));
        tbl.push_back(mk(0,1,0,3,0,1,0,0, 1,1,1,0,3,0,0,1));
        tbl.push_back(mk(0,1,0,3,0,1,0,0, 1,0,0,0,3,0,0,0));
        tbl.push_back(mk(0,1,0,3,0,1,1,0, 1,0,0,0,3,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,0, 0,0,0,0,3,0,0,0));
        // s1 read len=1, m_ready 1,0,1
        tbl.push_back(mk(0,0,1,0,1,1,1,0, 0,0,0,0,3,0,0,0));
        tbl.push_back(mk(0,0,1,0,1,1,0,0, 1,1,0,1,1,0,0,2));
        tbl.push_back(mk(0,0,1,0,1,0,0,0, 1,1,0,0,1,0,0,2));
        tbl.push_back(mk(0,0,1,0,1,1,0,0, 1,1,0,1,1,0,0,2));
        tbl.push_back(mk(0,0,0,0,1,1,1,0, 1,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,0, 0,0,0,0,1,0,0,0));
        // sticky error on s0, cleared at next s0 grant
        tbl.push_back(mk(0,1,0,1,0,1,1,0, 0,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,1,0,1,0,1,0,1, 1,1,1,0,1,0,0,1));
        tbl.push_back(mk(0,1,0,1,0,1,0,0, 1,1,1,0,1,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1,0, 1,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,0, 0,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,1,0, 0,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,0,0, 1,1,1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1,0, 1,0,0,0,0,0,0,0));
        // no grant while bridge not idle
        tbl.push_back(mk(0,1,0,0,0,1,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,1,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,0,0, 1,1,1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1,0, 1,0,0,0,0,0,0,0));
        // reset after 2 of 8 beats, with m_error in the same cycle
        tbl.push_back(mk(0,1,0,7,0,1,1,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,7,0,1,0,0, 1,1,1,0,7,0,0,1));
        tbl.push_back(mk(0,1,0,7,0,1,0,0, 1,1,1,0,7,0,0,1));
        tbl.push_back(mk(1,1,0,7,0,1,0,1, 1,1,1,0,7,0,0,1));
        tbl.push_back(mk(0,1,0,7,0,1,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,0, 0,0,0,0,0,0,0,0));
        // tie right after reset goes to s0 again
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,1,1,0, 1,1,1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,1,0, 1,0,0,0,0,0,0,0));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", -1, 64'(busy), 64'(0));
        chk("rst_mvalid", -1, 64'(m_valid), 64'(0));
        chk("rst_mlength", -1, 64'(m_length), 64'(0));
        chk("rst_err", -1, 64'({s0_error, s1_error}), 64'(0));
        chk("rst_ready", -1, 64'({s0_ready, s1_ready}), 64'(0));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            logic [DATA_W-1:0] rd;
            logic [ADDR_W-1:0] ea;
            logic [DATA_W-1:0] ed;
            logic [SW-1:0]     ew;
            v  = tbl[i];
            rd = 32'hD000_0000 + 32'(i);
            ea = (v.sel == 2'd1) ? A0 : (v.sel == 2'd2) ? A1 : '0;
            ed = (v.sel == 2'd1) ? D0 : (v.sel == 2'd2) ? D1 : '0;
            ew = (v.sel == 2'd1) ? W0 : (v.sel == 2'd2) ? W1 : '0;
            @(posedge clk);
            #1;
            rst      = v.rst;
            s0_valid = v.v0;
            s1_valid = v.v1;
            s0_len   = v.l0;
            s1_len   = v.l1;
            m_ready  = v.mrdy;
            m_idle   = v.midle;
            m_error  = v.merr;
            m_rdata  = rd;
            @(negedge clk);
            chk("busy", i, 64'(busy), 64'(v.busy));
            chk("m_valid", i, 64'(m_valid), 64'(v.mv));
            chk("s0_ready", i, 64'(s0_ready), 64'(v.rdy0));
            chk("s1_ready", i, 64'(s1_ready), 64'(v.rdy1));
            chk("m_length", i, 64'(m_length), 64'(v.mlen));
            chk("s0_error", i, 64'(s0_error), 64'(v.e0));
            chk("s1_error", i, 64'(s1_error), 64'(v.e1));
            chk("m_addr", i, 64'(m_addr), 64'(ea));
            chk("m_wdata", i, 64'(m_wdata), 64'(ed));
            chk("m_wstrb", i, 64'(m_wstrb), 64'(ew));
            chk("s0_rdata", i, 64'(s0_rdata),
                64'((v.sel == 2'd1) ? rd : '0));
            chk("s1_rdata", i, 64'(s1_rdata),
                64'((v.sel == 2'd2) ? rd : '0));
        end

        // s1 len=2 latched at grant, len change ignored; s0 waits and
        // is granted in the very first IDLE cycle after the drain.
        begin
            int s1_beats;
            int s0_beats;
            int s0_first;
            s1_beats = 0;
            s0_beats = 0;
            s0_first = -1;
            @(posedge clk);
            #1;
            rst = 1'b0; m_error = 1'b0;
            m_ready = 1'b1; m_idle = 1'b1;
            s0_valid = 1'b0; s1_valid = 1'b1; s1_len = 8'd2;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (m_valid && s1_ready) s1_beats++;
                if (m_valid && s0_ready) begin
                    if (s0_first < 0) s0_first = c;
                    s0_beats++;
                end
                if (c == 4) chk("hs_mlength", c, 64'(m_length), 64'(2));
                if (c == 5) chk("hs_gap_busy", c, 64'(busy), 64'(0));
                @(posedge clk);
                #1;
                if (c == 0) begin
                    s1_len = 8'd0;
                    s0_valid = 1'b1;
                    s0_len = 8'd0;
                end
                if (s1_beats == 3) s1_valid = 1'b0;
                if (s0_beats != 0) s0_valid = 1'b0;
            end
            chk("hs_s1_beats", 0, 64'(s1_beats), 64'(3));
            chk("hs_s0_beats", 0, 64'(s0_beats), 64'(1));
            chk("hs_s0_first", 0, 64'(s0_first), 64'(6));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
